// File: rtl/shift_pkg.sv
// Shared types for the universal shift register.
// Modes, burst FSM states and the count-width helper.
package shift_pkg;

  typedef enum logic [2:0] {
    M_HOLD = 3'd0,
    M_SHL  = 3'd1,
    M_SHR  = 3'd2,
    M_ROL  = 3'd3,
    M_ROR  = 3'd4,
    M_ASR  = 3'd5,
    M_LOAD = 3'd6,
    M_RSVD = 3'd7
  } shift_mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } sr_state_e;

  function automatic int cw_of(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/univ_shift_reg_if.sv
// Control/data bundle of the universal shift register.
// master drives requests, slave is the register itself.
interface univ_shift_reg_if
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
);

  localparam int CW = cw_of(WIDTH);

  logic             en;
  shift_mode_e      mode;
  logic             d;
  logic [WIDTH-1:0] par_in;
  logic             start;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] out;
  logic             so;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, d, par_in, start, count,
    input  out, so, busy, done
  );

  modport slave (
    input  en, mode, d, par_in, start, count,
    output out, so, busy, done
  );

endinterface

// File: rtl/shift_step.sv
// One-bit step of the shift register, purely combinational.
// Shared by the direct path and the burst engine.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] cur,
  input  shift_mode_e      mode,
  input  logic             d,
  input  logic [WIDTH-1:0] par_in,
  input  logic             so_cur,
  output logic [WIDTH-1:0] nxt,
  output logic             so_nxt
);

  always_comb begin
    nxt    = cur;
    so_nxt = so_cur;
    case (mode)
      M_SHL: begin
        nxt    = {cur[WIDTH-2:0], d};
        so_nxt = cur[WIDTH-1];
      end
      M_SHR: begin
        nxt    = {d, cur[WIDTH-1:1]};
        so_nxt = cur[0];
      end
      M_ROL: begin
        nxt    = {cur[WIDTH-2:0], cur[WIDTH-1]};
        so_nxt = cur[WIDTH-1];
      end
      M_ROR: begin
        nxt    = {cur[0], cur[WIDTH-1:1]};
        so_nxt = cur[0];
      end
      M_ASR: begin
        nxt    = {cur[WIDTH-1], cur[WIDTH-1:1]};
        so_nxt = cur[0];
      end
      M_LOAD: nxt = par_in;
      default: ;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: direct per-cycle ops plus
// a burst engine stepping N times with busy/done.
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rstn,
  univ_shift_reg_if.slave  bus
);

  localparam int CW = cw_of(WIDTH);

  sr_state_e        state, state_n;
  logic [CW-1:0]    rem, rem_n;
  shift_mode_e      lmode, lmode_n;
  shift_mode_e      smode;
  logic [WIDTH-1:0] out_q, out_n;
  logic             so_q, so_n;

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .cur    (out_q),
    .mode   (smode),
    .d      (bus.d),
    .par_in (bus.par_in),
    .so_cur (so_q),
    .nxt    (out_n),
    .so_nxt (so_n)
  );

  always_comb begin
    state_n = state;
    rem_n   = rem;
    lmode_n = lmode;
    smode   = M_HOLD;
    case (state)
      S_RUN: begin
        if (bus.en) begin
          smode = lmode;
          rem_n = rem - CW'(1);
          if (rem == CW'(1)) begin
            state_n = S_DONE;
          end
        end
      end
      default: begin
        state_n = S_IDLE;
        if (bus.start) begin
          lmode_n = bus.mode;
          // load and empty bursts finish at the accept edge
          if (bus.mode == M_LOAD) begin
            smode   = M_LOAD;
            state_n = S_DONE;
          end else if (bus.count == '0) begin
            state_n = S_DONE;
          end else begin
            rem_n   = bus.count;
            state_n = S_RUN;
          end
        end else if (bus.en) begin
          smode = bus.mode;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      rem   <= '0;
      lmode <= M_HOLD;
      out_q <= '0;
      so_q  <= 1'b0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      lmode <= lmode_n;
      out_q <= out_n;
      so_q  <= so_n;
    end
  end

  assign bus.out  = out_q;
  assign bus.so   = so_q;
  assign bus.busy = (state == S_RUN);
  assign bus.done = (state == S_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: directed scenarios with literal
// expectations plus random traffic against a behavioural model.
module tb_univ_shift_reg;
  import shift_pkg::*;

  logic clk;
  logic rstn;
  int   checks;
  int   errors;

  univ_shift_reg_if #(.WIDTH(16)) bus ();

  univ_shift_reg #(
    .WIDTH (16)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural model: pending step count replaces the FSM
  logic [15:0] m_out;
  logic        m_so;
  int          m_pend;
  logic        m_done;
  shift_mode_e m_bmode;

  function automatic logic [15:0] step_out(input shift_mode_e m,
                                           input logic [15:0] v,
                                           input logic dd,
                                           input logic [15:0] par);
    case (m)
      M_SHL:   return (v << 1) | 16'(dd);
      M_SHR:   return (v >> 1) | (16'(dd) << 15);
      M_ROL:   return (v << 1) | (v >> 15);
      M_ROR:   return (v >> 1) | (v << 15);
      M_ASR:   return 16'($signed(v) >>> 1);
      M_LOAD:  return par;
      default: return v;
    endcase
  endfunction

  function automatic logic step_so(input shift_mode_e m,
                                   input logic [15:0] v,
                                   input logic s);
    case (m)
      M_SHL, M_ROL:        return v[15];
      M_SHR, M_ROR, M_ASR: return v[0];
      default:             return s;
    endcase
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_out   <= '0;
      m_so    <= 1'b0;
      m_pend  <= 0;
      m_done  <= 1'b0;
      m_bmode <= M_HOLD;
    end else begin
      m_done <= 1'b0;
      if (m_pend != 0) begin
        if (bus.en) begin
          m_out  <= step_out(m_bmode, m_out, bus.d, bus.par_in);
          m_so   <= step_so(m_bmode, m_out, m_so);
          m_pend <= m_pend - 1;
          if (m_pend == 1) m_done <= 1'b1;
        end
      end else if (bus.start) begin
        if (bus.mode == M_LOAD) begin
          m_out  <= bus.par_in;
          m_done <= 1'b1;
        end else if (bus.count == 0) begin
          m_done <= 1'b1;
        end else begin
          m_pend  <= int'(bus.count);
          m_bmode <= bus.mode;
        end
      end else if (bus.en) begin
        m_out <= step_out(bus.mode, m_out, bus.d, bus.par_in);
        m_so  <= step_so(bus.mode, m_out, m_so);
      end
    end
  end

  always @(negedge clk) begin
    checks++;
    if (bus.out !== m_out || bus.so !== m_so ||
        bus.busy !== (m_pend != 0) || bus.done !== m_done) begin
      errors++;
      $display("FAIL model t=%0t out=%h so=%b busy=%b done=%b want out=%h so=%b busy=%b done=%b",
               $time, bus.out, bus.so, bus.busy, bus.done,
               m_out, m_so, (m_pend != 0), m_done);
    end
  end

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  task automatic lit(input string nm, input logic [15:0] exp);
    check({nm, "_dut"}, 32'(bus.out), 32'(exp));
    check({nm, "_model"}, 32'(m_out), 32'(exp));
  endtask

  task automatic cyc(input logic e, input shift_mode_e m,
                     input logic dd, input logic [15:0] par,
                     input logic st, input logic [4:0] cnt);
    bus.en     = e;
    bus.mode   = m;
    bus.d      = dd;
    bus.par_in = par;
    bus.start  = st;
    bus.count  = cnt;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic burst(input shift_mode_e m, input logic dd,
                       input logic [4:0] cnt, input int pause_at,
                       input int pause_len, input bit noise,
                       output int nbusy, output int lat);
    int i;
    cyc(1'b1, m, dd, 16'h0, 1'b1, cnt);
    lat   = 1;
    nbusy = 0;
    i     = 0;
    while (!bus.done && lat < 80) begin
      if (bus.busy) nbusy++;
      cyc(!(i >= pause_at && i < pause_at + pause_len),
          noise ? shift_mode_e'($urandom_range(0, 7)) : M_HOLD,
          dd, 16'($urandom), noise,
          noise ? 5'($urandom_range(0, 31)) : 5'd0);
      lat++;
      i++;
    end
    bus.start = 1'b0;
    bus.en    = 1'b0;
    check("burst_done_seen", 32'(bus.done), 32'd1);
    check("burst_busy_at_done", 32'(bus.busy), 32'd0);
  endtask

  int nb, lt;

  initial begin
    checks     = 0;
    errors     = 0;
    rstn       = 1'b0;
    bus.en     = 1'b0;
    bus.mode   = M_HOLD;
    bus.d      = 1'b0;
    bus.par_in = '0;
    bus.start  = 1'b0;
    bus.count  = '0;
    @(negedge clk);
    @(negedge clk);
    lit("reset_out", 16'h0000);
    check("reset_so", 32'(bus.so), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    rstn = 1'b1;

    // async reset in the middle of a burst
    cyc(1'b1, M_LOAD, 1'b0, 16'hA5A5, 1'b0, 5'd0);
    lit("load_a5a5", 16'hA5A5);
    cyc(1'b1, M_SHL, 1'b1, 16'h0, 1'b1, 5'd5);
    cyc(1'b1, M_HOLD, 1'b1, 16'h0, 1'b0, 5'd0);
    cyc(1'b1, M_HOLD, 1'b1, 16'h0, 1'b0, 5'd0);
    check("midburst_busy", 32'(bus.busy), 32'd1);
    #2 rstn = 1'b0;
    #1;
    lit("rst_abort_out", 16'h0000);
    check("rst_abort_so", 32'(bus.so), 32'd0);
    check("rst_abort_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    check("rst_no_done", 32'(bus.done), 32'd0);
    rstn = 1'b1;
    burst(M_SHL, 1'b1, 5'd2, 99, 0, 1'b0, nb, lt);
    check("post_rst_lat", 32'(lt), 32'd3);
    lit("post_rst_out", 16'h0003);

    // direct ops
    cyc(1'b1, M_LOAD, 1'b0, 16'h8001, 1'b0, 5'd0);
    cyc(1'b1, M_SHL, 1'b1, 16'h0, 1'b0, 5'd0);
    lit("shl_out", 16'h0003);
    check("shl_so", 32'(bus.so), 32'd1);
    cyc(1'b1, M_SHR, 1'b0, 16'h0, 1'b0, 5'd0);
    lit("shr_out", 16'h0001);
    check("shr_so", 32'(bus.so), 32'd1);
    cyc(1'b0, M_SHL, 1'b1, 16'h0, 1'b0, 5'd0);
    lit("en_low_hold", 16'h0001);

    // rotate bursts
    cyc(1'b1, M_LOAD, 1'b0, 16'h1234, 1'b0, 5'd0);
    burst(M_ROR, 1'b0, 5'd16, 99, 0, 1'b0, nb, lt);
    check("ror16_busy", 32'(nb), 32'd16);
    check("ror16_lat", 32'(lt), 32'd17);
    lit("ror16_out", 16'h1234);
    cyc(1'b0, M_HOLD, 1'b0, 16'h0, 1'b0, 5'd0);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    burst(M_ROR, 1'b0, 5'd4, 99, 0, 1'b0, nb, lt);
    lit("ror4_out", 16'h4123);

    // arithmetic shift
    cyc(1'b1, M_LOAD, 1'b0, 16'h8000, 1'b0, 5'd0);
    burst(M_ASR, 1'b1, 5'd4, 99, 0, 1'b0, nb, lt);
    lit("asr4_out", 16'hF800);
    check("asr4_so", 32'(bus.so), 32'd0);

    // pause mid-burst
    cyc(1'b1, M_LOAD, 1'b0, 16'h8000, 1'b0, 5'd0);
    burst(M_SHR, 1'b0, 5'd3, 1, 2, 1'b0, nb, lt);
    check("pause_lat", 32'(lt), 32'd6);
    check("pause_busy", 32'(nb), 32'd5);
    lit("pause_out", 16'h1000);

    // zero-length burst
    burst(M_SHL, 1'b1, 5'd0, 99, 0, 1'b0, nb, lt);
    check("cnt0_lat", 32'(lt), 32'd1);
    check("cnt0_busy", 32'(nb), 32'd0);
    lit("cnt0_out", 16'h1000);

    // start during RUN is ignored
    cyc(1'b1, M_LOAD, 1'b0, 16'h0001, 1'b0, 5'd0);
    burst(M_ROL, 1'b0, 5'd3, 99, 0, 1'b1, nb, lt);
    check("noise_lat", 32'(lt), 32'd4);
    lit("noise_out", 16'h0008);

    // back-to-back from the DONE cycle
    cyc(1'b1, M_LOAD, 1'b0, 16'h0001, 1'b0, 5'd0);
    burst(M_ROL, 1'b0, 5'd2, 99, 0, 1'b0, nb, lt);
    lit("b2b_first", 16'h0004);
    burst(M_ROL, 1'b0, 5'd3, 99, 0, 1'b0, nb, lt);
    check("b2b_lat", 32'(lt), 32'd4);
    lit("b2b_second", 16'h0020);

    // random traffic, checked every cycle by the model
    for (int k = 0; k < 1500; k++) begin
      cyc($urandom_range(0, 3) != 0,
          shift_mode_e'($urandom_range(0, 7)),
          1'($urandom), 16'($urandom),
          $urandom_range(0, 9) == 0,
          5'($urandom_range(0, 20)));
      if ($urandom_range(0, 399) == 0) begin
        #2 rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
